control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 117 +++++++++++
 tb/tb_control_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM: fetch, PC update, decode, then per-instruction
// execute states. Outputs are registered and always match the current state.
module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       loadir,
    output logic       loadpc,
    output logic       msel,
    output logic       mwrite,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DEC, S_WR_IMM, S_GET_A, S_GET_B,
        S_ALU, S_CMP, S_WR_C, S_ADDR, S_MEM_RD, S_LD_WR, S_STORE, S_HALT
    } state_t;

    state_t     cur, nxt;
    logic       bad_code;
    logic       n_loadir, n_loadpc, n_msel, n_mwrite, n_write;
    logic       n_loada, n_loadb, n_loadc, n_loads, n_asel, n_bsel, n_halted;
    logic [1:0] n_nsel, n_vsel;

    wire is_ldr = (opcode == 3'b011);
    wire is_str = (opcode == 3'b100);
    wire is_cmp = ({opcode, op} == 5'b101_01);
    wire alu_zero_a = ({opcode, op} == 5'b110_00) || ({opcode, op} == 5'b101_11);

    assign state = cur;

    always_comb begin
        nxt      = cur;
        bad_code = 1'b0;
        unique case (cur)
            S_RST:    nxt = S_IF1;
            S_IF1:    nxt = S_IF2;
            S_IF2:    nxt = S_UPD_PC;
            S_UPD_PC: nxt = S_DEC;
            S_DEC: begin
                casez ({opcode, op})
                    5'b110_10:                       nxt = S_WR_IMM;
                    5'b110_00, 5'b101_11:            nxt = S_GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: nxt = S_GET_A;
                    5'b011_00, 5'b100_00:            nxt = S_GET_A;
                    5'b111_??:                       nxt = S_HALT;
                    default: begin
                        nxt      = S_HALT;
                        bad_code = 1'b1;
                    end
                endcase
            end
            S_GET_A:  nxt = (is_ldr || is_str) ? S_ADDR : S_GET_B;
            S_GET_B:  nxt = is_str ? S_STORE : (is_cmp ? S_CMP : S_ALU);
            S_ALU:    nxt = S_WR_C;
            S_ADDR:   nxt = is_ldr ? S_MEM_RD : S_GET_B;
            S_MEM_RD: nxt = S_LD_WR;
            S_WR_IMM, S_WR_C, S_CMP, S_LD_WR, S_STORE: nxt = S_IF1;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_RST;
        endcase
    end

    // Output values for the state being entered, so registers track the state.
    always_comb begin
        n_loadir = 1'b0; n_loadpc = 1'b0; n_msel  = 1'b0; n_mwrite = 1'b0;
        n_write  = 1'b0; n_loada  = 1'b0; n_loadb = 1'b0; n_loadc  = 1'b0;
        n_loads  = 1'b0; n_asel   = 1'b0; n_bsel  = 1'b0; n_halted = 1'b0;
        n_nsel   = 2'b00; n_vsel  = 2'b00;
        unique case (nxt)
            S_IF1:    n_msel = 1'b1;
            S_IF2:    begin n_msel = 1'b1; n_loadir = 1'b1; end
            S_UPD_PC: n_loadpc = 1'b1;
            S_WR_IMM: begin n_vsel = 2'b01; n_write = 1'b1; end
            S_GET_A:  n_loada = 1'b1;
            S_GET_B:  begin n_loadb = 1'b1; n_nsel = is_str ? 2'b01 : 2'b10; end
            S_ALU:    begin n_loadc = 1'b1; n_asel = alu_zero_a; end
            S_CMP:    n_loads = 1'b1;
            S_WR_C:   begin n_nsel = 2'b01; n_vsel = 2'b11; n_write = 1'b1; end
            S_ADDR:   begin n_bsel = 1'b1; n_loadc = 1'b1; end
            S_LD_WR:  begin n_nsel = 2'b01; n_write = 1'b1; end
            S_STORE:  n_mwrite = 1'b1;
            S_HALT:   n_halted = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_RST;
            loadir  <= 1'b0; loadpc <= 1'b0; msel  <= 1'b0; mwrite <= 1'b0;
            nsel    <= 2'b00; vsel  <= 2'b00; write <= 1'b0;
            loada   <= 1'b0; loadb  <= 1'b0; loadc <= 1'b0; loads  <= 1'b0;
            asel    <= 1'b0; bsel   <= 1'b0; halted <= 1'b0; illegal <= 1'b0;
        end else begin
            cur     <= nxt;
            loadir  <= n_loadir; loadpc <= n_loadpc; msel  <= n_msel; mwrite <= n_mwrite;
            nsel    <= n_nsel;   vsel   <= n_vsel;   write <= n_write;
            loada   <= n_loada;  loadb  <= n_loadb;  loadc <= n_loadc; loads  <= n_loads;
            asel    <= n_asel;   bsel   <= n_bsel;   halted <= n_halted;
            illegal <= illegal | bad_code;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboarded bench for control_fsm: each instruction pushes its expected
// per-cycle output vectors, which are popped and compared on falling edges.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       loadir, loadpc, msel, mwrite, write;
    logic       loada, loadb, loadc, loads, asel, bsel, halted, illegal;
    logic [1:0] nsel, vsel;
    logic [3:0] state;

    control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .loadir(loadir), .loadpc(loadpc), .msel(msel), .mwrite(mwrite),
        .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .halted(halted), .illegal(illegal),
        .state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Output vector layout, MSB first.
    wire [16:0] outv = {loadir, loadpc, msel, mwrite, nsel, vsel, write,
                        loada, loadb, loadc, loads, asel, bsel, halted, illegal};

    localparam logic [16:0] LOADIR  = 17'h10000, LOADPC  = 17'h08000;
    localparam logic [16:0] MSEL    = 17'h04000, MWRITE  = 17'h02000;
    localparam logic [16:0] NSEL_RD = 17'h00800, NSEL_RM = 17'h01000;
    localparam logic [16:0] VSEL_IM = 17'h00200, VSEL_C  = 17'h00600;
    localparam logic [16:0] WRITE   = 17'h00100, LOADA   = 17'h00080;
    localparam logic [16:0] LOADB   = 17'h00040, LOADC   = 17'h00020;
    localparam logic [16:0] LOADS   = 17'h00010, ASEL    = 17'h00008;
    localparam logic [16:0] BSEL    = 17'h00004, HALTED  = 17'h00002;
    localparam logic [16:0] ILLEGAL = 17'h00001;

    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: expected vectors for one instruction, IF1 through its last state
    task automatic push_instr(input logic [2:0] opc, input logic [1:0] opv);
        exp_q.push_back(MSEL);
        exp_q.push_back(MSEL | LOADIR);
        exp_q.push_back(LOADPC);
        exp_q.push_back(17'h0);
        case ({opc, opv})
            5'b110_10: exp_q.push_back(WRITE | VSEL_IM);
            5'b110_00, 5'b101_11: begin
                exp_q.push_back(LOADB | NSEL_RM);
                exp_q.push_back(LOADC | ASEL);
                exp_q.push_back(WRITE | NSEL_RD | VSEL_C);
            end
            5'b101_00, 5'b101_10: begin
                exp_q.push_back(LOADA);
                exp_q.push_back(LOADB | NSEL_RM);
                exp_q.push_back(LOADC);
                exp_q.push_back(WRITE | NSEL_RD | VSEL_C);
            end
            5'b101_01: begin
                exp_q.push_back(LOADA);
                exp_q.push_back(LOADB | NSEL_RM);
                exp_q.push_back(LOADS);
            end
            5'b011_00: begin
                exp_q.push_back(LOADA);
                exp_q.push_back(BSEL | LOADC);
                exp_q.push_back(17'h0);
                exp_q.push_back(WRITE | NSEL_RD);
            end
            5'b100_00: begin
                exp_q.push_back(LOADA);
                exp_q.push_back(BSEL | LOADC);
                exp_q.push_back(LOADB | NSEL_RD);
                exp_q.push_back(MWRITE);
            end
            default: begin
                for (int i = 0; i < 22; i++)
                    exp_q.push_back((opc == 3'b111) ? HALTED : (HALTED | ILLEGAL));
            end
        endcase
    endtask

    // scoreboard: pop and compare one vector per falling edge
    task automatic drain(input string tag, input int n);
        logic [16:0] e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check(tag, 32'(outv), 32'(e));
            if (mwrite && write) check("mwrite_write_excl", 32'(mwrite & write), 32'd0);
        end
    endtask

    task automatic run_instr(input string tag, input logic [2:0] opc, input logic [1:0] opv);
        opcode = opc;
        op     = opv;
        push_instr(opc, opv);
        drain(tag, exp_q.size());
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        #1 check("reset_async", 32'(outv), 32'd0);
        @(negedge clk);
        check("reset_state", 32'(outv), 32'd0);
        reset = 1'b0;
    endtask

    logic [4:0] legal[8] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10,
                             5'b101_01, 5'b101_11, 5'b011_00, 5'b100_00};

    initial begin
        logic [4:0] code;
        reset  = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        #2 reset = 1'b1;
        do_reset();

        run_instr("mov_imm", 3'b110, 2'b10);
        run_instr("add",     3'b101, 2'b00);
        run_instr("cmp",     3'b101, 2'b01);
        run_instr("ldr",     3'b011, 2'b00);
        run_instr("str",     3'b100, 2'b00);
        run_instr("mov_reg", 3'b110, 2'b00);
        run_instr("mvn",     3'b101, 2'b11);
        run_instr("and",     3'b101, 2'b10);

        for (int k = 0; k < 30; k++) begin
            code = legal[$urandom_range(0, 7)];
            run_instr("rand", code[4:2], code[1:0]);
        end

        // Reset during ALU of an ADD: the pending WR_C must never happen.
        opcode = 3'b101;
        op     = 2'b00;
        push_instr(3'b101, 2'b00);
        drain("add_partial", 7);
        exp_q.delete();
        #1 reset = 1'b1;
        #1 check("midreset_async", 32'(outv), 32'd0);
        @(negedge clk);
        check("midreset_no_wrc", 32'(write), 32'd0);
        check("midreset_hold", 32'(outv), 32'd0);
        reset = 1'b0;
        run_instr("after_reset", 3'b110, 2'b10);

        run_instr("illegal", 3'b000, 2'b00);
        do_reset();
        run_instr("mov_after_ill", 3'b110, 2'b10);
        run_instr("halt", 3'b111, 2'b01);
        do_reset();
        run_instr("illegal2", 3'b110, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
